// File: rtl/mmio_bus_pkg.sv
// Shared types for the MMIO bus master: FSM state encoding and the queued
// command record.
package mmio_bus_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACCESS,
      ST_RESP
   } state_t;

   typedef struct packed {
      logic        write;
      logic [31:0] address;
      logic [31:0] wdata;
   } cmd_t;

   localparam int CMD_W = $bits(cmd_t);
   localparam int LAT_W = 4;

endpackage

// File: rtl/mmio_bus_master_sync_fifo.sv
// Synchronous FIFO with full/empty flags; the head entry is read directly
// from the register storage.
module sync_fifo #(
   parameter int WIDTH = 65,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_rdata,
   output logic             o_full,
   output logic             o_empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW:0]      r_wr_ptr;
   logic [AW:0]      r_rd_ptr;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (i_push) r_wr_ptr <= r_wr_ptr + (AW + 1)'(1);
         if (i_pop)  r_rd_ptr <= r_rd_ptr + (AW + 1)'(1);
      end
   end

   // NOTE: storage is deliberately not reset; the pointers alone decide which entries are valid.
   always_ff @(posedge clk) begin
      if (i_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
   end

   assign o_rdata = r_mem[r_rd_ptr[AW-1:0]];
   assign o_empty = (r_wr_ptr == r_rd_ptr);
   assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                    (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

endmodule

// File: rtl/mmio_bus_master.sv
// In-order MMIO bus initiator: buffers commands, runs one registered bus
// access per command and returns one response per command.
module mmio_bus_master
   import mmio_bus_pkg::*;
#(
   parameter int FIFO_DEPTH   = 4,
   parameter int READ_LATENCY = 0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_write,
   input  logic [31:0] cmd_address,
   input  logic [31:0] cmd_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic        rsp_write,
   output logic [31:0] rsp_rdata,
   output logic        read,
   output logic        write,
   output logic [31:0] address,
   output logic [31:0] write_data,
   input  logic [31:0] read_data
);

   localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(READ_LATENCY);

   cmd_t             w_push_cmd;
   cmd_t             w_head_cmd;
   logic             w_push;
   logic             w_pop;
   logic             w_full;
   logic             w_empty;

   state_t           r_state;
   logic [LAT_W-1:0] r_lat_cnt;
   logic             r_read;
   logic             r_write;
   logic [31:0]      r_address;
   logic [31:0]      r_wdata;
   logic             r_rsp_valid;
   logic             r_rsp_write;
   logic [31:0]      r_rsp_rdata;

   assign w_push_cmd = '{write: cmd_write, address: cmd_address, wdata: cmd_wdata};
   assign w_push     = cmd_valid && !w_full;
   assign w_pop      = (r_state == ST_IDLE) && !w_empty;

   sync_fifo #(
      .WIDTH (CMD_W),
      .DEPTH (FIFO_DEPTH)
   ) u_cmd_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_push  (w_push),
      .i_wdata (w_push_cmd),
      .i_pop   (w_pop),
      .o_rdata (w_head_cmd),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   // NOTE: non-blocking assignments so every register updates from its pre-edge value.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_lat_cnt   <= '0;
         r_read      <= 1'b0;
         r_write     <= 1'b0;
         r_address   <= '0;
         r_wdata     <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_write <= 1'b0;
         r_rsp_rdata <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (!w_empty) begin
                  r_read      <= !w_head_cmd.write;
                  r_write     <= w_head_cmd.write;
                  r_address   <= w_head_cmd.address;
                  r_wdata     <= w_head_cmd.write ? w_head_cmd.wdata : 32'h0;
                  r_lat_cnt   <= LAT_INIT;
                  r_rsp_write <= w_head_cmd.write;
                  r_state     <= ST_ACCESS;
               end
            end
            ST_ACCESS: begin
               // Writes last one cycle; reads hold until the countdown reaches 0.
               if (r_write || (r_lat_cnt == '0)) begin
                  r_rsp_rdata <= r_read ? read_data : 32'h0;
                  r_read      <= 1'b0;
                  r_write     <= 1'b0;
                  r_address   <= '0;
                  r_wdata     <= '0;
                  r_rsp_valid <= 1'b1;
                  r_state     <= ST_RESP;
               end else begin
                  r_lat_cnt <= r_lat_cnt - LAT_W'(1);
               end
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_state     <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign cmd_ready  = !w_full;
   assign rsp_valid  = r_rsp_valid;
   assign rsp_write  = r_rsp_write;
   assign rsp_rdata  = r_rsp_rdata;
   assign read       = r_read;
   assign write      = r_write;
   assign address    = r_address;
   assign write_data = r_wdata;

endmodule
